sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_pkg.sv | 41 ++++
 rtl/sram_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared constants, FSM state encoding and address helper for the
//            SRAM data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // Byte address that maps onto SRAM word 0
  localparam int unsigned c_DATA_MEM_BASE = 32'd1024;

  // External SRAM geometry: 16-bit half-words, 18-bit half-word address
  localparam int unsigned c_SRAM_DATA_W = 16;
  localparam int unsigned c_SRAM_ADDR_W = 18;

  // One 32-bit word occupies two half-words, so the word index is one bit
  // narrower than the SRAM address
  localparam int unsigned c_WORD_IDX_W = c_SRAM_ADDR_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC_LO = 3'd1,
    ST_ACC_HI = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } sram_state_e;

  // Word index of a byte address relative to the data-memory base.
  // Upper bits beyond the SRAM range are dropped on purpose.
  function automatic logic [c_WORD_IDX_W-1:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] offset;
    offset = addr - base;
    return c_WORD_IDX_W'(offset >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Brief    : Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous
//            SRAM as two half-word accesses plus a settle period, stalling
//            the pipeline through 'ready' while the access is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES   = 3,
  parameter int unsigned DATA_MEM_BASE = c_DATA_MEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  // Counter only needs to reach WAIT_CYCLES-1; keep it at least one bit wide
  // so WAIT_CYCLES of 0 or 1 still elaborates.
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  sram_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [c_WORD_IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       is_wr_q, is_wr_d;
  logic [31:0]                read_data_q;

  logic                       dq_oe;
  logic [c_SRAM_DATA_W-1:0]   dq_out;
  logic                       req;

  assign req = rd_en | wr_en;

  // State, settle counter and the operation latched at request acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next-state logic and all SRAM-side / pipeline-side controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    ready     = 1'b0;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b0;
    dq_oe     = 1'b0;
    dq_out    = '0;

    case (state_q)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          // Store wins when both are asserted
          state_d = ST_ACC_LO;
          idx_d   = word_index(address, 32'(DATA_MEM_BASE));
          wdata_d = write_data;
          is_wr_d = wr_en;
        end
      end

      ST_ACC_LO: begin
        SRAM_ADDR = {idx_q, 1'b0};
        if (is_wr_q) begin
          SRAM_WE_N = 1'b0;
          SRAM_OE_N = 1'b1;
          dq_oe     = 1'b1;
          dq_out    = wdata_q[15:0];
        end
        state_d = ST_ACC_HI;
      end

      ST_ACC_HI: begin
        SRAM_ADDR = {idx_q, 1'b1};
        if (is_wr_q) begin
          SRAM_WE_N = 1'b0;
          SRAM_OE_N = 1'b1;
          dq_oe     = 1'b1;
          dq_out    = wdata_q[31:16];
        end
        cnt_d   = '0;
        state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load result: low half captured leaving ACC_LO, high half leaving ACC_HI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= '0;
    end else if (!is_wr_q && (state_q == ST_ACC_LO)) begin
      read_data_q[15:0] <= SRAM_DQ;
    end else if (!is_wr_q && (state_q == ST_ACC_HI)) begin
      read_data_q[31:16] <= SRAM_DQ;
    end
  end

  assign read_data = read_data_q;
  assign SRAM_DQ   = dq_oe ? dq_out : {c_SRAM_DATA_W{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
`default_nettype wire
